ens_vote_accum: RTL and testbench

ENS_VOTE_ACCUM -- requirements
Module: ens_vote_accum

---
 rtl/ens_vote_accum.sv | 145 ++++++++++++++
 tb/tb_ens_vote_accum.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ens_vote_accum.sv
// ens_vote_accum -- ensemble vote accumulator.
//
// Sums NUM_MEMBERS score vectors class by class. It then scans the sums,
// one class per cycle, to find the arg-max. On a tie the lowest class
// index wins. The decision is held until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a member score vector is on in_data
//   in_ready   a member vector is accepted this cycle (ACCUM state only)
//   in_data    NUM_CLASSES x SCORE_W scores, class k at [k*SCORE_W +: SCORE_W]
//   out_valid  a decision is presented (HOLD state)
//   out_ready  the consumer takes the decision
//   out_class  winning class index (0 while out_valid=0)
//   out_score  winning accumulated score (0 while out_valid=0)
//   out_scores all accumulators, packed like in_data (0 while out_valid=0);
//              this port exists only when ENS_ACC_SCORES_EN is defined
//
// Optional feature macro: ENS_ACC_SCORES_EN
module ens_vote_accum #(
  parameter int NUM_CLASSES = 5,
  parameter int SCORE_W     = 2,
  parameter int NUM_MEMBERS = 4,
  localparam int ACC_W      = SCORE_W + $clog2(NUM_MEMBERS),
  localparam int CLS_W      = $clog2(NUM_CLASSES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CLASSES*SCORE_W-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CLS_W-1:0]             out_class,
  output logic [ACC_W-1:0]             out_score
`ifdef ENS_ACC_SCORES_EN
  ,
  output logic [NUM_CLASSES*ACC_W-1:0] out_scores
`endif
);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // The member counter only needs to reach NUM_MEMBERS-1. The final beat
  // clears it instead of storing NUM_MEMBERS.
  localparam int              CNT_W       = $clog2(NUM_MEMBERS);
  localparam logic [CNT_W-1:0] LAST_MEMBER = CNT_W'(NUM_MEMBERS - 1);
  localparam logic [CLS_W-1:0] LAST_CLASS  = CLS_W'(NUM_CLASSES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] member_cnt;
  logic [CLS_W-1:0] scan_idx;
  logic [CLS_W-1:0] best_class;
  logic [ACC_W-1:0] best_score;
  logic [ACC_W-1:0] acc [NUM_CLASSES];

  logic accept;
  logic consume;

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // NOTE: all state below uses non-blocking assignments. Every register then
  //       samples pre-edge values, whatever order the statements run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACCUM;
      member_cnt <= '0;
      scan_idx   <= '0;
      best_class <= '0;
      best_score <= '0;
      // NOTE: the accumulators are reset explicitly. A reset in mid-decision
      //       must discard partial sums, so this array cannot be left uninitialised.
      for (int k = 0; k < NUM_CLASSES; k++) acc[k] <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            // The unsigned cast zero-extends each slice. ACC_W holds the
            // worst-case sum, so no carry can be lost.
            for (int k = 0; k < NUM_CLASSES; k++)
              acc[k] <= acc[k] + ACC_W'(in_data[k*SCORE_W +: SCORE_W]);
            if (member_cnt == LAST_MEMBER) begin
              member_cnt <= '0;
              scan_idx   <= '0;
              state      <= ST_SCAN;
            end else begin
              member_cnt <= member_cnt + CNT_W'(1);
            end
          end
        end

        ST_SCAN: begin
          // Class 0 seeds the best value unconditionally. A later class
          // replaces it only if strictly greater, so ties keep the lower index.
          if (scan_idx == '0 || acc[scan_idx] > best_score) begin
            best_score <= acc[scan_idx];
            best_class <= scan_idx;
          end
          if (scan_idx == LAST_CLASS) state    <= ST_HOLD;
          else                        scan_idx <= scan_idx + CLS_W'(1);
        end

        ST_HOLD: begin
          if (consume) begin
            for (int k = 0; k < NUM_CLASSES; k++) acc[k] <= '0;
            best_class <= '0;
            best_score <= '0;
            state      <= ST_ACCUM;
          end
        end

        default: state <= ST_ACCUM;
      endcase
    end
  end

  // The result fields read as zero whenever no decision is presented.
  // NOTE: every output gets a default first. Otherwise the out_valid=0
  //       path would infer latches.
  always_comb begin
    out_class = '0;
    out_score = '0;
    if (out_valid) begin
      out_class = best_class;
      out_score = best_score;
    end
  end

`ifdef ENS_ACC_SCORES_EN
  always_comb begin
    out_scores = '0;
    if (out_valid) begin
      for (int k = 0; k < NUM_CLASSES; k++)
        out_scores[k*ACC_W +: ACC_W] = acc[k];
    end
  end
`endif

endmodule

// File: tb/tb_ens_vote_accum.sv
// Self-checking bench for ens_vote_accum (default parameters).
// Inputs are driven and outputs sampled on the falling edge.
module tb_ens_vote_accum;

  localparam int NC    = 5;
  localparam int SW    = 2;
  localparam int NM    = 4;
  localparam int AW    = SW + $clog2(NM);
  localparam int CW    = $clog2(NC);
  localparam int BOUND = 50;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [NC*SW-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [CW-1:0]      out_class;
  logic [AW-1:0]      out_score;
`ifdef ENS_ACC_SCORES_EN
  logic [NC*AW-1:0]   out_scores;
`endif

  ens_vote_accum #(.NUM_CLASSES(NC), .SCORE_W(SW), .NUM_MEMBERS(NM)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
`ifdef ENS_ACC_SCORES_EN
    ,
    .out_scores(out_scores)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per-class totals of the beats accepted for this decision.
  int totals [NC];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [NC*SW-1:0] pack5(input int c0, c1, c2, c3, c4);
    logic [NC*SW-1:0] v;
    v = '0;
    v[0*SW +: SW] = SW'(c0);
    v[1*SW +: SW] = SW'(c1);
    v[2*SW +: SW] = SW'(c2);
    v[3*SW +: SW] = SW'(c3);
    v[4*SW +: SW] = SW'(c4);
    return v;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NC; k++) totals[k] = 0;
  endtask

  // Reset for one cycle. A handshake attempted in the same cycle must be ignored.
  task automatic do_reset(input logic with_traffic);
    rst = 1'b1;
    if (with_traffic) begin
      in_valid  = 1'b1;
      in_data   = pack5(3, 3, 3, 3, 3);
      out_ready = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clear_model();
  endtask

  // Present one member vector after `gap` idle cycles and wait for acceptance.
  // While idle, in_data carries junk that must not be summed.
  task automatic beat(input logic [NC*SW-1:0] d, input int gap);
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = NC*SW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("beat_accept_timeout", 0, 1);
    else begin
      check("no_valid_while_accepting", out_valid, 0);
      for (int k = 0; k < NC; k++) totals[k] += int'(d[k*SW +: SW]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Call right after the final beat. Checks latency, result and
  // stability over `hold` stalled cycles, then the release handshake.
  task automatic decide(input string tag, input int hold);
    int n, mx, exp_cls;
    logic busy_ok, stable_ok;
    logic [CW-1:0] cap_cls;
    logic [AW-1:0] cap_scr;
`ifdef ENS_ACC_SCORES_EN
    logic [NC*AW-1:0] exp_scores;
`endif
    n = 0;
    busy_ok = 1'b1;
    while (!out_valid && n < BOUND) begin
      if (in_ready || out_class != '0 || out_score != '0) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, NC);
    check({tag, "_scan_idle_outputs"}, busy_ok, 1);
    // Expected result: the maximum total, taken at its first occurrence.
    mx = 0;
    for (int k = 0; k < NC; k++) if (totals[k] > mx) mx = totals[k];
    exp_cls = 0;
    for (int k = NC - 1; k >= 0; k--) if (totals[k] == mx) exp_cls = k;
    check({tag, "_class"}, out_class, exp_cls);
    check({tag, "_score"}, out_score, mx);
    check({tag, "_in_ready_hold"}, in_ready, 0);
`ifdef ENS_ACC_SCORES_EN
    exp_scores = '0;
    for (int k = 0; k < NC; k++) exp_scores[k*AW +: AW] = AW'(totals[k]);
    check({tag, "_scores"}, out_scores, exp_scores);
`endif
    cap_cls = out_class;
    cap_scr = out_score;
    stable_ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_class != cap_cls || out_score != cap_scr)
        stable_ok = 1'b0;
    end
    if (hold > 0) check({tag, "_hold_stable"}, stable_ok, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_released"}, {out_valid, in_ready}, 2'b01);
    check({tag, "_zero_after"}, {out_class, out_score}, '0);
    clear_model();
  endtask

  initial begin
    logic quiet_ok;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_fields", {out_class, out_score}, '0);

    // Single dominant class: class 2 gets 3 per member.
    repeat (NM) beat(pack5(0, 0, 3, 0, 0), 0);
    decide("dominant", 0);

    // Totals {5,7,7,2,0}: classes 1 and 2 tie and the lower index wins.
    beat(pack5(2, 2, 2, 1, 0), 0);
    beat(pack5(1, 2, 2, 1, 0), 1);
    beat(pack5(1, 2, 2, 0, 0), 0);
    beat(pack5(1, 1, 1, 0, 0), 2);
    check("tie_model_sanity", totals[1], 7);
    decide("tie", 0);

    // Long back-pressure in HOLD, then a fresh decision starting from cleared sums.
    repeat (NM) beat(pack5(1, 0, 0, 3, 2), 0);
    decide("backpressure", 10);
    repeat (NM) beat(pack5(0, 1, 0, 0, 0), 0);
    decide("after_release", 0);

    // Random in_valid gaps, all scores saturated: every class reaches 12.
    repeat (NM) beat(pack5(3, 3, 3, 3, 3), int'($urandom_range(0, 3)));
    decide("all_max", 0);

    // Reset after two beats, with a simultaneous input beat that must be ignored.
    repeat (2) beat(pack5(3, 3, 3, 3, 3), 0);
    do_reset(1'b1);
    check("mid_accum_reset_ready", in_ready, 1);
    repeat (NM) beat(pack5(0, 0, 0, 0, 1), 0);
    decide("after_accum_reset", 0);

    // Reset during SCAN: the pending decision is dropped.
    repeat (NM) beat(pack5(3, 0, 0, 0, 0), 0);
    @(negedge clk);
    do_reset(1'b0);
    check("scan_reset_ready", in_ready, 1);
    quiet_ok = 1'b1;
    repeat (8) begin
      if (out_valid || !in_ready) quiet_ok = 1'b0;
      @(negedge clk);
    end
    check("scan_reset_no_valid", quiet_ok, 1);
    repeat (NM) beat(pack5(0, 2, 0, 1, 0), 0);
    decide("after_scan_reset", 0);

    // Randomized decisions against the model.
    for (int d = 0; d < 25; d++) begin
      for (int b = 0; b < NM; b++)
        beat(NC*SW'($urandom), int'($urandom_range(0, 2)));
      decide("random", int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so that a stuck design still ends the run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
